// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers, optional majority glitch filter and bus event detection.
// Define I2C_REG_SLAVE_GLITCH_FILTER_EN to insert the 3-sample majority filter.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [1:0] scl_ff, sda_ff;
  logic       scl_line, sda_line;
  logic       scl_prev, sda_prev;

  // Sync flops reset to the idle-bus level so reset release raises no events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
    end
  end

`ifdef I2C_REG_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_filt, sda_filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_ff[1]};
      sda_hist <= {sda_hist[0], sda_ff[1]};
      scl_filt <= majority3(scl_ff[1], scl_hist[0], scl_hist[1]);
      sda_filt <= majority3(sda_ff[1], sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_line = scl_filt;
  assign sda_line = sda_filt;
`else
  assign scl_line = scl_ff[1];
  assign sda_line = sda_ff[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda       <= 1'b1;
    end else begin
      scl_prev  <= scl_line;
      sda_prev  <= sda_line;
      scl_rise  <= scl_line & ~scl_prev;
      scl_fall  <= ~scl_line & scl_prev;
      start_det <= scl_line & scl_prev & sda_prev & ~sda_line;
      stop_det  <= scl_line & scl_prev & ~sda_prev & sda_line;
      sda       <= sda_line;
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// Single-clock I2C register target with pointer auto-increment and burst access.
// Optional macro I2C_REG_SLAVE_GLITCH_FILTER_EN enables input glitch filtering.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h55,
  parameter int         NREGS = 16,
  parameter int         PTR_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  i2c_state_t       state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, shift_in;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, wr_addr_n;
  logic [7:0]       wr_data_n;
  logic             rw, rw_n, sda_oe_n, busy_n, wr_valid_n;

  assign rd_addr  = ptr;
  assign shift_in = {shreg[6:0], sda};
  assign ptr_inc  = (ptr == PTR_W'(NREGS - 1)) ? '0 : ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

  // In the ACK states bit_cnt marks whether the ACK is already being driven.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ptr_n      = ptr;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;

    if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              case (state)
                ST_ADDR: begin
                  if (shift_in[7:1] == ADDR) begin
                    state_n = ST_ADDR_ACK;
                    rw_n    = shift_in[RW_BIT];
                    busy_n  = 1'b1;
                  end else begin
                    state_n = ST_WAIT_STOP;
                    busy_n  = 1'b0;
                  end
                end
                ST_PTR: begin
                  if ({1'b0, shift_in} < 9'(NREGS)) begin
                    ptr_n   = shift_in[PTR_W-1:0];
                    state_n = ST_PTR_ACK;
                  end else begin
                    state_n = ST_WAIT_STOP;
                  end
                end
                default: begin
                  wr_valid_n = 1'b1;
                  wr_addr_n  = ptr;
                  wr_data_n  = shift_in;
                  ptr_n      = ptr_inc;
                  state_n    = ST_WR_ACK;
                end
              endcase
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n  = ~I2C_ACK;
              bit_cnt_n = 4'd1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              shreg_n   = '0;
              if (state == ST_ADDR_ACK && rw) begin
                state_n   = ST_RD_DATA;
                shreg_n   = rd_data;
                ptr_n     = ptr_inc;
                sda_oe_n  = ~rd_data[7];
                bit_cnt_n = 4'd1;
              end else if (state == ST_ADDR_ACK) begin
                state_n = ST_PTR;
              end else begin
                state_n = ST_WR_DATA;
              end
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n   = ST_RD_ACK;
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              sda_oe_n  = ~shreg[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) state_n = ST_WAIT_STOP;
            else                 bit_cnt_n = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_n   = ST_RD_DATA;
            shreg_n   = rd_data;
            ptr_n     = ptr_inc;
            sda_oe_n  = ~rd_data[7];
            bit_cnt_n = 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged master, write log, immediate assertions.
module tb_i2c_reg_slave;

  localparam int TQ = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int tests = 0;
  int failed = 0;
  logic [3:0] log_addr[$];
  logic [7:0] log_data[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = {4'h0, rd_addr} ^ 8'hF0;

  i2c_reg_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (TQ) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         n0;

    // Reset state
    repeat (5) @(negedge clk);
    check_output("rst sda_oe", sda_oe, 0);
    check_output("rst wr_valid", wr_valid, 0);
    check_output("rst wr_addr", wr_addr, 0);
    check_output("rst wr_data", wr_data, 0);
    check_output("rst rd_addr", rd_addr, 0);
    check_output("rst busy", busy, 0);
    rst_n = 1'b1;
    wait_q();

    // Burst write: ptr 3, data 0x11, 0x22
    bus_start();
    write_byte(8'hAA, ack); check_output("bw addr ack", ack, 0);
    check_output("bw busy", busy, 1);
    write_byte(8'h03, ack); check_output("bw ptr ack", ack, 0);
    write_byte(8'h11, ack); check_output("bw d0 ack", ack, 0);
    write_byte(8'h22, ack); check_output("bw d1 ack", ack, 0);
    bus_stop();
    check_output("bw busy after stop", busy, 0);
    check_output("bw strobe count", log_addr.size(), 2);
    check_output("bw wa0", log_addr[0], 3);
    check_output("bw wd0", log_data[0], 8'h11);
    check_output("bw wa1", log_addr[1], 4);
    check_output("bw wd1", log_data[1], 8'h22);
    check_output("bw rd_addr", rd_addr, 5);

    // Random read: ptr 5, repeated START, read two bytes
    bus_start();
    write_byte(8'hAA, ack); check_output("rr addr ack", ack, 0);
    write_byte(8'h05, ack); check_output("rr ptr ack", ack, 0);
    bus_start();
    write_byte(8'hAB, ack); check_output("rr raddr ack", ack, 0);
    read_byte(1'b0, d); check_output("rr byte0", d, 8'hF5);
    read_byte(1'b1, d); check_output("rr byte1", d, 8'hF6);
    check_output("rr sda released", sda_oe, 0);
    wait_q();
    check_output("rr sda still released", sda_oe, 0);
    bus_stop();
    check_output("rr rd_addr", rd_addr, 7);
    check_output("rr no strobes", log_addr.size(), 2);

    // Address mismatch
    bus_start();
    write_byte(8'hA8, ack); check_output("mm addr nack", ack, 1);
    check_output("mm busy", busy, 0);
    write_byte(8'h01, ack); check_output("mm byte nack", ack, 1);
    write_byte(8'h33, ack);
    bus_stop();
    check_output("mm no strobes", log_addr.size(), 2);

    // Pointer out of range
    bus_start();
    write_byte(8'hAA, ack); check_output("pe addr ack", ack, 0);
    write_byte(8'h20, ack); check_output("pe ptr nack", ack, 1);
    write_byte(8'h44, ack);
    bus_stop();
    check_output("pe no strobes", log_addr.size(), 2);
    check_output("pe ptr kept", rd_addr, 7);

    // Pointer wrap 15 -> 0
    bus_start();
    write_byte(8'hAA, ack);
    write_byte(8'h0F, ack); check_output("wr ptr ack", ack, 0);
    write_byte(8'h5A, ack);
    write_byte(8'hA5, ack); check_output("wr d1 ack", ack, 0);
    bus_stop();
    check_output("wr strobe count", log_addr.size(), 4);
    check_output("wr wa0", log_addr[2], 15);
    check_output("wr wd0", log_data[2], 8'h5A);
    check_output("wr wa1", log_addr[3], 0);
    check_output("wr wd1", log_data[3], 8'hA5);
    check_output("wr rd_addr", rd_addr, 1);

    // Reset while driving a 0 data bit (rd_data 0xF1)
    bus_start();
    write_byte(8'hAB, ack); check_output("mr addr ack", ack, 0);
    for (int i = 0; i < 4; i++) read_bit(ack);
    check_output("mr sda driven", sda_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("mr sda_oe", sda_oe, 0);
    check_output("mr rd_addr", rd_addr, 0);
    check_output("mr wr_addr", wr_addr, 0);
    check_output("mr busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_q();
    bus_stop();
    n0 = log_addr.size();
    bus_start();
    write_byte(8'hAA, ack); check_output("mr2 addr ack", ack, 0);
    write_byte(8'h02, ack); check_output("mr2 ptr ack", ack, 0);
    write_byte(8'h77, ack); check_output("mr2 data ack", ack, 0);
    bus_stop();
    check_output("mr2 strobe count", log_addr.size(), n0 + 1);
    check_output("mr2 wa", log_addr[n0], 2);
    check_output("mr2 wd", log_data[n0], 8'h77);

    // One-clock SCL glitch ahead of the bits 0101010
    bus_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1; @(negedge clk);
    scl = 1'b0; wait_q();
    for (int i = 0; i < 7; i++) write_bit(i[0]);
    read_bit(ack);
`ifdef I2C_REG_SLAVE_GLITCH_FILTER_EN
    check_output("glitch filtered", ack, 1);
`else
    check_output("glitch counted", ack, 0);
`endif
    bus_stop();
    check_output("end busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
